// File: rtl/matrix_trans_pkg.sv
// Shared types and sizing helpers for the matrix frame source and transpose blocks.
package matrix_trans_pkg;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

   typedef enum logic {PAT_ASC = 1'b0, PAT_DESC = 1'b1} pat_e;

   // Counter width for an index range 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      if (n <= 32'd1) begin
         return 32'd1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/matrix_idx_cnt.sv
// Row-major col/row index counter pair; col wraps at CLO-1 and carries into row.
module matrix_idx_cnt #(
   parameter int ROW = 64,
   parameter int CLO = 2400
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             en,
   input  logic                                             clr,
   output logic [matrix_trans_pkg::cnt_width(CLO)-1:0]      col,
   output logic [matrix_trans_pkg::cnt_width(ROW)-1:0]      row,
   output logic                                             end_of_row,
   output logic                                             end_of_frame
);
   import matrix_trans_pkg::*;

   localparam int CW = cnt_width(CLO);
   localparam int RW = cnt_width(ROW);

   logic [CW-1:0] col_r, col_nxt_s;
   logic [RW-1:0] row_r, row_nxt_s;

   assign col          = col_r;
   assign row          = row_r;
   assign end_of_row   = (col_r == CW'(CLO - 1));
   assign end_of_frame = end_of_row && (row_r == RW'(ROW - 1));

   // Next index: clear dominates, otherwise advance on enable.
   always_comb begin
      col_nxt_s = col_r;
      row_nxt_s = row_r;
      if (clr) begin
         col_nxt_s = {CW{1'b0}};
         row_nxt_s = {RW{1'b0}};
      end else if (en) begin
         if (end_of_frame) begin
            col_nxt_s = {CW{1'b0}};
            row_nxt_s = {RW{1'b0}};
         end else if (end_of_row) begin
            col_nxt_s = {CW{1'b0}};
            row_nxt_s = row_r + RW'(1);
         end else begin
            col_nxt_s = col_r + CW'(1);
            row_nxt_s = row_r;
         end
      end else begin
         col_nxt_s = col_r;
         row_nxt_s = row_r;
      end
   end

   // Index registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         col_r <= {CW{1'b0}};
         row_r <= {RW{1'b0}};
      end else begin
         col_r <= col_nxt_s;
         row_r <= row_nxt_s;
      end
   end

endmodule

// File: rtl/matrix_frame_src.sv
// AXI-Stream source of ROW x CLO frames alternating ascending/descending column ramps,
// with full tready backpressure and registered outputs.
module matrix_frame_src #(
   parameter int DATA_WIDTH = 32,
   parameter int ROW        = 64,
   parameter int CLO        = 2400,
   parameter int FCNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [FCNT_WIDTH-1:0] frame_num,
   input  logic                  stop,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic                  frame_done,
   output logic [FCNT_WIDTH-1:0] frame_cnt
);
   import matrix_trans_pkg::*;

   localparam int CW = cnt_width(CLO);
   localparam int RW = cnt_width(ROW);

   state_e                state_r, state_nxt_s;
   pat_e                  pattern_r, pattern_nxt_s;
   logic [FCNT_WIDTH-1:0] frames_left_r, frames_left_nxt_s, frame_cnt_nxt_s;
   logic                  stop_r, stop_nxt_s, stop_pend_s, more_s;
   logic                  hs_s, cnt_en_s, cnt_clr_s;
   logic [CW-1:0]         col_s, ncol_s;
   logic [RW-1:0]         row_s, nrow_s;
   logic                  eor_s, eof_s;
   logic [DATA_WIDTH-1:0] tdata_nxt_s;
   logic                  tvalid_nxt_s, tuser_nxt_s, tlast_nxt_s, done_nxt_s;

   function automatic logic [DATA_WIDTH-1:0] pix(input logic [CW-1:0] c, input pat_e p);
      logic [DATA_WIDTH-1:0] cx;
      cx = DATA_WIDTH'(c);
      case (p)
         PAT_DESC: pix = DATA_WIDTH'(CLO) - cx;
         PAT_ASC:  pix = cx;
         default:  pix = cx;
      endcase
   endfunction

   matrix_idx_cnt #(.ROW(ROW), .CLO(CLO)) u_idx (
      .clk          (clk),
      .rst          (rst),
      .en           (cnt_en_s),
      .clr          (cnt_clr_s),
      .col          (col_s),
      .row          (row_s),
      .end_of_row   (eor_s),
      .end_of_frame (eof_s)
   );

   assign hs_s        = m_axis_tvalid & m_axis_tready;
   assign stop_pend_s = stop_r | stop;
   // frames_left of zero while sending marks continuous mode; counted mode stops at one.
   assign more_s      = ((frames_left_r == {FCNT_WIDTH{1'b0}}) || (frames_left_r > FCNT_WIDTH'(1)))
                        && !stop_pend_s;
   assign ncol_s      = eor_s ? {CW{1'b0}} : col_s + CW'(1);
   assign nrow_s      = eor_s ? row_s + RW'(1) : row_s;

   // Next state and next registered output values; output registers load the beat
   // that will be presented after the current handshake.
   always_comb begin
      state_nxt_s       = state_r;
      pattern_nxt_s     = pattern_r;
      frames_left_nxt_s = frames_left_r;
      frame_cnt_nxt_s   = frame_cnt;
      stop_nxt_s        = stop_r;
      cnt_en_s          = 1'b0;
      cnt_clr_s         = 1'b0;
      tdata_nxt_s       = m_axis_tdata;
      tvalid_nxt_s      = m_axis_tvalid;
      tuser_nxt_s       = m_axis_tuser;
      tlast_nxt_s       = m_axis_tlast;
      done_nxt_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s       = SEND;
               pattern_nxt_s     = PAT_ASC;
               frames_left_nxt_s = frame_num;
               frame_cnt_nxt_s   = {FCNT_WIDTH{1'b0}};
               stop_nxt_s        = 1'b0;
               cnt_clr_s         = 1'b1;
               tvalid_nxt_s      = 1'b1;
               tdata_nxt_s       = pix({CW{1'b0}}, PAT_ASC);
               tuser_nxt_s       = 1'b1;
               tlast_nxt_s       = (CLO == 1);
            end else begin
               stop_nxt_s        = 1'b0;
            end
         end
         SEND: begin
            if (hs_s) begin
               cnt_en_s = 1'b1;
               if (eof_s) begin
                  done_nxt_s      = 1'b1;
                  frame_cnt_nxt_s = frame_cnt + FCNT_WIDTH'(1);
                  stop_nxt_s      = 1'b0;
                  if (frames_left_r != {FCNT_WIDTH{1'b0}}) begin
                     frames_left_nxt_s = frames_left_r - FCNT_WIDTH'(1);
                  end else begin
                     frames_left_nxt_s = frames_left_r;
                  end
                  if (more_s) begin
                     pattern_nxt_s = (pattern_r == PAT_ASC) ? PAT_DESC : PAT_ASC;
                     tvalid_nxt_s  = 1'b1;
                     tdata_nxt_s   = pix({CW{1'b0}}, pattern_nxt_s);
                     tuser_nxt_s   = 1'b1;
                     tlast_nxt_s   = (CLO == 1);
                  end else begin
                     state_nxt_s   = IDLE;
                     tvalid_nxt_s  = 1'b0;
                     tdata_nxt_s   = {DATA_WIDTH{1'b0}};
                     tuser_nxt_s   = 1'b0;
                     tlast_nxt_s   = 1'b0;
                  end
               end else begin
                  stop_nxt_s  = stop_pend_s;
                  tdata_nxt_s = pix(ncol_s, pattern_r);
                  tuser_nxt_s = (ncol_s == {CW{1'b0}}) && (nrow_s == {RW{1'b0}});
                  tlast_nxt_s = (ncol_s == CW'(CLO - 1));
               end
            end else begin
               stop_nxt_s = stop_pend_s;
            end
         end
         default: begin
            state_nxt_s  = IDLE;
            tvalid_nxt_s = 1'b0;
         end
      endcase
   end

   // State, bookkeeping and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= IDLE;
         pattern_r     <= PAT_ASC;
         frames_left_r <= {FCNT_WIDTH{1'b0}};
         stop_r        <= 1'b0;
         m_axis_tdata  <= {DATA_WIDTH{1'b0}};
         m_axis_tvalid <= 1'b0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         frame_cnt     <= {FCNT_WIDTH{1'b0}};
      end else begin
         state_r       <= state_nxt_s;
         pattern_r     <= pattern_nxt_s;
         frames_left_r <= frames_left_nxt_s;
         stop_r        <= stop_nxt_s;
         m_axis_tdata  <= tdata_nxt_s;
         m_axis_tvalid <= tvalid_nxt_s;
         m_axis_tuser  <= tuser_nxt_s;
         m_axis_tlast  <= tlast_nxt_s;
         busy          <= (state_nxt_s == SEND);
         frame_done    <= done_nxt_s;
         frame_cnt     <= frame_cnt_nxt_s;
      end
   end

endmodule
